// File: rtl/div_if.sv
// Divider handshake bundle between the execute stage (master) and div_unit (slave).
interface div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, annul, a, b,
    input  stall, ready, result
  );

  modport slave (
    input  start, signed_div, annul, a, b,
    output stall, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock, stalls the
// pipeline while busy and returns {HI = remainder, LO = quotient}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  // 0x80000000 maps to itself, which is the correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  always_comb begin
    // Trial subtraction needs one extra bit: the shifted remainder can reach 2*divisor-1.
    trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_nxt = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.b == '0) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {bus.a, {WIDTH{1'b1}}};
          end else begin
            state_d = RUN;
            count_d = CNT_W'(WIDTH - 1);
            rem_d   = '0;
            quo_d   = abs_val(bus.a, bus.signed_div);
            dvs_d   = abs_val(bus.b, bus.signed_div);
            neg_q_d = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r_d = bus.signed_div & bus.a[WIDTH-1];
          end
        end
      end
      RUN: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        if (count_q == '0) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = {cond_neg(rem_nxt, neg_r_q), cond_neg(quo_nxt, neg_q_q)};
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flushed instruction leaves no trace on the architectural result.
    if (bus.annul) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.stall  = ~rst & ~bus.annul & (((state_q == IDLE) & bus.start) | (state_q == RUN));
  assign bus.ready  = ready_q;
  assign bus.result = result_q;
endmodule
